// File: rtl/jtframe_bank_resp_if.sv
// Request/response bundle of one SDRAM bank channel: rd/wr in, ack/dst/dok/rdy out.
interface jtframe_bank_resp_if #(
    parameter int AW = 22
);
    logic [AW-1:0] addr;
    logic          rd;
    logic          wr;
    logic [15:0]   din;
    logic [1:0]    din_m;
    logic          ack;
    logic          dst;
    logic          dok;
    logic          rdy;
    logic [15:0]   dout;

    modport master (
        output addr, rd, wr, din, din_m,
        input  ack, dst, dok, rdy, dout
    );

    modport slave (
        input  addr, rd, wr, din, din_m,
        output ack, dst, dok, rdy, dout
    );
endinterface

// File: rtl/jtframe_bank_resp.sv
// Block-RAM stand-in for one SDRAM bank: same handshake, configurable burst and latency.
// Define JTFRAME_BANKRESP_JITTER_EN to add LFSR-driven random read latency and burst gaps.
//
// state | meaning
// IDLE  | waiting for rd/wr (ignored while prog_en)
// RWAIT | read accepted, counting down to the first data word
// BURST | streaming the remaining read words
// WDONE | write accepted, memory written this cycle, rdy next
module jtframe_bank_resp #(
    parameter int AW   = 22,
    parameter int MEMW = 12,
    parameter int LEN  = 32,
    parameter int LAT  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    jtframe_bank_resp_if.slave    bus,
    input  logic                  prog_en,
    input  logic                  prog_we,
    input  logic [MEMW-1:0]       prog_addr,
    input  logic [15:0]           prog_din
);
    localparam int BL = LEN / 16;
    localparam logic [4:0] CNT0 = 5'(LAT - 2);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RWAIT = 2'd1;
    localparam logic [1:0] BURST = 2'd2;
    localparam logic [1:0] WDONE = 2'd3;

    logic [1:0]      st;
    logic [MEMW-1:0] ptr;
    logic [15:0]     wdata;
    logic [1:0]      wmask;
    logic [4:0]      cnt;
    logic [1:0]      left;
    logic [4:0]      extra;
    logic            hold;
    logic            unused_addr;

    logic [15:0] mem [0:(1<<MEMW)-1];

    assign unused_addr = ^bus.addr[AW-1:MEMW];

`ifdef JTFRAME_BANKRESP_JITTER_EN
    logic [15:0] lfsr;
    logic        gap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= 16'hACE1;
            gap  <= 1'b0;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            gap  <= (st == BURST) && hold;
        end
    end

    // one inserted idle cycle at most per word
    assign hold  = lfsr[2] & ~gap;
    assign extra = {3'b000, lfsr[1:0]};
`else
    assign hold  = 1'b0;
    assign extra = 5'd0;
`endif

    // a loader write to the same word lands after the responder write and wins
    always_ff @(posedge clk) begin
        if (st == WDONE) begin
            if (!wmask[1]) mem[ptr][15:8] <= wdata[15:8];
            if (!wmask[0]) mem[ptr][7:0]  <= wdata[7:0];
        end
        if (prog_we) mem[prog_addr] <= prog_din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= IDLE;
            bus.ack  <= 1'b0;
            bus.dst  <= 1'b0;
            bus.dok  <= 1'b0;
            bus.rdy  <= 1'b0;
            bus.dout <= 16'h0000;
            ptr      <= '0;
            wdata    <= 16'h0000;
            wmask    <= 2'b00;
            cnt      <= 5'd0;
            left     <= 2'd0;
        end else begin
            bus.ack <= 1'b0;
            bus.dst <= 1'b0;
            bus.dok <= 1'b0;
            bus.rdy <= 1'b0;
            case (st)
                IDLE: begin
                    if ((bus.rd | bus.wr) & ~prog_en) begin
                        bus.ack <= 1'b1;
                        ptr     <= bus.addr[MEMW-1:0];
                        wdata   <= bus.din;
                        wmask   <= bus.din_m;
                        if (bus.wr) begin
                            st <= WDONE;
                        end else begin
                            st  <= RWAIT;
                            cnt <= CNT0 + extra;
                        end
                    end
                end
                RWAIT: begin
                    if (cnt == 5'd0) begin
                        bus.dok  <= 1'b1;
                        bus.dst  <= 1'b1;
                        bus.dout <= mem[ptr];
                        ptr      <= ptr + 1'b1;
                        left     <= 2'(BL - 1);
                        if (BL == 1) begin
                            bus.rdy <= 1'b1;
                            st      <= IDLE;
                        end else begin
                            st <= BURST;
                        end
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                BURST: begin
                    if (!hold) begin
                        bus.dok  <= 1'b1;
                        bus.dout <= mem[ptr];
                        ptr      <= ptr + 1'b1;
                        left     <= left - 2'd1;
                        if (left == 2'd1) begin
                            bus.rdy <= 1'b1;
                            st      <= IDLE;
                        end
                    end
                end
                WDONE: begin
                    bus.rdy <= 1'b1;
                    st      <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule
